// File: rtl/uart_boot_loader.sv
// uart_boot_loader: receives a framed program image over UART and writes it to boot RAM
// over a valid/ready bus, holding the CPU in reset until the checksum verifies.  Rev 1.0
`default_nettype none

module uart_boot_loader #(
  parameter int CLKS_PER_BIT = 217
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rx_i,
  output logic        mem_valid_o,
  output logic [15:0] mem_addr_o,
  output logic [15:0] mem_wdata_o,
  output logic [1:0]  mem_wstrb_o,
  input  logic        mem_ready_i,
  output logic        done_o,
  output logic        error_o,
  output logic        cpu_rst_o
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT + 1);
  localparam logic [CNT_W-1:0] c_bit_last  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] c_half_last = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [7:0]       c_sync_byte = 8'hA5;

  typedef enum logic [1:0] {
    RX_IDLE  = 2'd0,
    RX_START = 2'd1,
    RX_DATA  = 2'd2,
    RX_STOP  = 2'd3
  } rx_state_t;

  typedef enum logic [3:0] {
    S_SYNC    = 4'd0,
    S_ADDR_H  = 4'd1,
    S_ADDR_L  = 4'd2,
    S_LEN_H   = 4'd3,
    S_LEN_L   = 4'd4,
    S_DATA_LO = 4'd5,
    S_DATA_HI = 4'd6,
    S_WRITE   = 4'd7,
    S_CHECK   = 4'd8,
    S_DONE    = 4'd9,
    S_ERROR   = 4'd10
  } state_t;

  // ---------------- UART receiver ----------------
  logic             rx_meta_q, rx_sync_q, rx_hist_q;
  rx_state_t        rx_state_q, rx_state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       bit_idx_q, bit_idx_d;
  logic [7:0]       shift_q, shift_d;
  logic             w_rx_done, w_frame_err, w_start_edge;

  assign w_start_edge = rx_hist_q & ~rx_sync_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta_q  <= 1'b1;
      rx_sync_q  <= 1'b1;
      rx_hist_q  <= 1'b1;
      rx_state_q <= RX_IDLE;
      cnt_q      <= '0;
      bit_idx_q  <= '0;
      shift_q    <= '0;
    end else begin
      rx_meta_q  <= rx_i;
      rx_sync_q  <= rx_meta_q;
      rx_hist_q  <= rx_sync_q;
      rx_state_q <= rx_state_d;
      cnt_q      <= cnt_d;
      bit_idx_q  <= bit_idx_d;
      shift_q    <= shift_d;
    end
  end

  always_comb begin
    rx_state_d  = rx_state_q;
    cnt_d       = cnt_q;
    bit_idx_d   = bit_idx_q;
    shift_d     = shift_q;
    w_rx_done   = 1'b0;
    w_frame_err = 1'b0;
    case (rx_state_q)
      RX_IDLE: begin
        cnt_d = '0;
        if (w_start_edge) rx_state_d = RX_START;
      end
      RX_START: begin
        if (cnt_q == c_half_last) begin
          cnt_d      = '0;
          bit_idx_d  = '0;
          // A glitch that is high again at mid-bit is not a start bit
          rx_state_d = rx_sync_q ? RX_IDLE : RX_DATA;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RX_DATA: begin
        if (cnt_q == c_bit_last) begin
          cnt_d   = '0;
          shift_d = {rx_sync_q, shift_q[7:1]};
          if (bit_idx_q == 3'd7) rx_state_d = RX_STOP;
          else                   bit_idx_d  = bit_idx_q + 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RX_STOP: begin
        if (cnt_q == c_bit_last) begin
          cnt_d       = '0;
          rx_state_d  = RX_IDLE;
          w_rx_done   = rx_sync_q;
          w_frame_err = ~rx_sync_q;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: rx_state_d = RX_IDLE;
    endcase
  end

  // ---------------- byte buffer ----------------
  logic       buf_full_q, buf_full_d;
  logic [7:0] buf_data_q, buf_data_d;
  logic       w_consume, w_overrun;
  state_t     state_q, state_d;

  always_comb begin
    w_consume = 1'b0;
    case (state_q)
      S_SYNC, S_ADDR_H, S_ADDR_L, S_LEN_H, S_LEN_L,
      S_DATA_LO, S_DATA_HI, S_CHECK, S_DONE, S_ERROR: w_consume = buf_full_q;
      default:                                        w_consume = 1'b0;
    endcase
  end

  assign w_overrun = w_rx_done & buf_full_q & ~w_consume;

  always_comb begin
    buf_full_d = buf_full_q;
    buf_data_d = buf_data_q;
    if (w_consume) buf_full_d = 1'b0;
    if (w_rx_done) begin
      buf_full_d = 1'b1;
      buf_data_d = shift_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      buf_full_q <= 1'b0;
      buf_data_q <= '0;
    end else begin
      buf_full_q <= buf_full_d;
      buf_data_q <= buf_data_d;
    end
  end

  // ---------------- loader FSM ----------------
  logic [7:0]  addr_h_q, addr_h_d, len_h_q, len_h_d, csum_q, csum_d;
  logic [15:0] addr_q, addr_d, rem_q, rem_d, wdata_q, wdata_d, w_rem_after;
  logic [1:0]  wstrb_q, wstrb_d;
  logic        valid_q, valid_d, done_q, done_d, error_q, error_d, cpu_rst_q, cpu_rst_d;

  assign w_rem_after = rem_q - ((wstrb_q == 2'b11) ? 16'd2 : 16'd1);

  always_comb begin
    state_d  = state_q;
    addr_h_d = addr_h_q;
    len_h_d  = len_h_q;
    csum_d   = csum_q;
    addr_d   = addr_q;
    rem_d    = rem_q;
    wdata_d  = wdata_q;
    wstrb_d  = wstrb_q;
    valid_d  = valid_q;
    case (state_q)
      S_SYNC:   if (w_consume && buf_data_q == c_sync_byte) state_d = S_ADDR_H;
      S_ADDR_H: if (w_consume) begin
        addr_h_d = buf_data_q;
        state_d  = S_ADDR_L;
      end
      S_ADDR_L: if (w_consume) begin
        if (buf_data_q[0]) begin
          state_d = S_ERROR;
        end else begin
          addr_d  = {addr_h_q, buf_data_q};
          state_d = S_LEN_H;
        end
      end
      S_LEN_H:  if (w_consume) begin
        len_h_d = buf_data_q;
        state_d = S_LEN_L;
      end
      S_LEN_L:  if (w_consume) begin
        rem_d   = {len_h_q, buf_data_q};
        state_d = ({len_h_q, buf_data_q} == 16'd0) ? S_CHECK : S_DATA_LO;
      end
      S_DATA_LO: if (w_consume) begin
        wdata_d = {8'h00, buf_data_q};
        csum_d  = csum_q + buf_data_q;
        if (rem_q == 16'd1) begin
          wstrb_d = 2'b01;
          valid_d = 1'b1;
          state_d = S_WRITE;
        end else begin
          state_d = S_DATA_HI;
        end
      end
      S_DATA_HI: if (w_consume) begin
        wdata_d = {buf_data_q, wdata_q[7:0]};
        csum_d  = csum_q + buf_data_q;
        wstrb_d = 2'b11;
        valid_d = 1'b1;
        state_d = S_WRITE;
      end
      S_WRITE: if (valid_q && mem_ready_i) begin
        // Drop valid on the completion edge so the RAM never sees a second access
        valid_d = 1'b0;
        addr_d  = addr_q + 16'd2;
        rem_d   = w_rem_after;
        state_d = (w_rem_after == 16'd0) ? S_CHECK : S_DATA_LO;
      end
      S_CHECK:  if (w_consume) state_d = (buf_data_q == csum_q) ? S_DONE : S_ERROR;
      S_DONE:   state_d = S_DONE;
      S_ERROR:  if (mem_ready_i) valid_d = 1'b0;
      default:  state_d = S_ERROR;
    endcase
    // An in-flight write keeps valid until its ready; ERROR then lets it drop
    if ((w_frame_err || w_overrun) && state_q != S_DONE) state_d = S_ERROR;
  end

  assign done_d    = done_q  | (state_d == S_DONE);
  assign error_d   = error_q | (state_d == S_ERROR);
  assign cpu_rst_d = ~done_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_SYNC;
      addr_h_q  <= '0;
      len_h_q   <= '0;
      csum_q    <= '0;
      addr_q    <= '0;
      rem_q     <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      valid_q   <= 1'b0;
      done_q    <= 1'b0;
      error_q   <= 1'b0;
      cpu_rst_q <= 1'b1;
    end else begin
      state_q   <= state_d;
      addr_h_q  <= addr_h_d;
      len_h_q   <= len_h_d;
      csum_q    <= csum_d;
      addr_q    <= addr_d;
      rem_q     <= rem_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      valid_q   <= valid_d;
      done_q    <= done_d;
      error_q   <= error_d;
      cpu_rst_q <= cpu_rst_d;
    end
  end

  assign mem_valid_o = valid_q;
  assign mem_addr_o  = addr_q;
  assign mem_wdata_o = wdata_q;
  assign mem_wstrb_o = wstrb_q;
  assign done_o      = done_q;
  assign error_o     = error_q;
  assign cpu_rst_o   = cpu_rst_q;

endmodule

`default_nettype wire

// File: tb/tb_uart_boot_loader.sv
// tb_uart_boot_loader: table-driven frames over UART against a one-cycle-ready RAM model.
// Rev 1.0
`default_nettype none

module tb_uart_boot_loader;

  localparam int CPB = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rx = 1'b1;
  logic        mem_valid, mem_ready = 1'b0;
  logic [15:0] mem_addr, mem_wdata;
  logic [1:0]  mem_wstrb;
  logic        done, error, cpu_rst;

  int errors = 0;
  int checks = 0;

  uart_boot_loader #(.CLKS_PER_BIT(CPB)) dut (
    .clk         (clk),
    .rst         (rst),
    .rx_i        (rx),
    .mem_valid_o (mem_valid),
    .mem_addr_o  (mem_addr),
    .mem_wdata_o (mem_wdata),
    .mem_wstrb_o (mem_wstrb),
    .mem_ready_i (mem_ready),
    .done_o      (done),
    .error_o     (error),
    .cpu_rst_o   (cpu_rst)
  );

  always #5 clk = ~clk;

  // RAM: registered one-cycle ready pulse per request
  always @(posedge clk) mem_ready <= mem_valid && !mem_ready;

  logic [33:0] wlog [$];
  int          ready_cnt = 0;
  int          stab_viol = 0;
  logic        pv = 1'b0, pr = 1'b0;
  logic [33:0] pw = '0;

  always @(negedge clk) begin
    if (mem_ready) ready_cnt++;
    if (mem_valid && mem_ready) wlog.push_back({mem_wstrb, mem_addr, mem_wdata});
    if (mem_valid && pv && !pr && ({mem_wstrb, mem_addr, mem_wdata} != pw)) stab_viol++;
    pv = mem_valid;
    pr = mem_ready;
    pw = {mem_wstrb, mem_addr, mem_wdata};
  end

  typedef struct packed {
    logic [95:0] b;      // frame bytes, first byte in [95:88]
    logic [3:0]  n;
    logic [3:0]  bad;    // index of byte sent with stop bit 0; 15 = none
    logic [1:0]  nwr;
    logic [15:0] a0, d0;
    logic [1:0]  s0;
    logic [15:0] a1, d1;
    logic [1:0]  s1;
    logic        exp_done, exp_err;
  } vec_t;

  localparam int NV = 7;
  vec_t vecs [NV];

  function automatic vec_t mk(input logic [95:0] b, input logic [3:0] n, input logic [3:0] bad,
                              input logic [1:0] nwr, input logic [15:0] a0, input logic [15:0] d0,
                              input logic [1:0] s0, input logic [15:0] a1, input logic [15:0] d1,
                              input logic [1:0] s1, input logic ed, input logic ee);
    vec_t v;
    v.b = b; v.n = n; v.bad = bad; v.nwr = nwr;
    v.a0 = a0; v.d0 = d0; v.s0 = s0; v.a1 = a1; v.d1 = d1; v.s1 = s1;
    v.exp_done = ed; v.exp_err = ee;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_bit);
    rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int k = 0; k < 8; k++) begin
      rx = b[k];
      repeat (CPB) @(negedge clk);
    end
    rx = stop_bit;
    repeat (CPB) @(negedge clk);
    rx = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    rx  = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    int          base;
    int          rbase;
    logic [33:0] e;
    logic [7:0]  fb;
    bit          seen;

    vecs[0] = mk(96'hA5_00_10_00_04_11_22_33_44_AA_00_00, 4'd10, 4'd15, 2'd2,
                 16'h0010, 16'h2211, 2'b11, 16'h0012, 16'h4433, 2'b11, 1'b1, 1'b0);
    vecs[1] = mk(96'hA5_00_20_00_03_01_02_03_06_00_00_00, 4'd9, 4'd15, 2'd2,
                 16'h0020, 16'h0201, 2'b11, 16'h0022, 16'h0003, 2'b01, 1'b1, 1'b0);
    vecs[2] = mk(96'h00_FF_A5_00_00_00_00_00_00_00_00_00, 4'd8, 4'd15, 2'd0,
                 16'h0, 16'h0, 2'b00, 16'h0, 16'h0, 2'b00, 1'b1, 1'b0);
    vecs[3] = mk(96'hA5_00_10_00_02_11_22_00_00_00_00_00, 4'd8, 4'd15, 2'd1,
                 16'h0010, 16'h2211, 2'b11, 16'h0, 16'h0, 2'b00, 1'b0, 1'b1);
    vecs[4] = mk(96'hA5_00_11_00_00_00_00_00_00_00_00_00, 4'd3, 4'd15, 2'd0,
                 16'h0, 16'h0, 2'b00, 16'h0, 16'h0, 2'b00, 1'b0, 1'b1);
    vecs[5] = mk(96'hA5_00_00_00_00_00_00_00_00_00_00_00, 4'd2, 4'd1, 2'd0,
                 16'h0, 16'h0, 2'b00, 16'h0, 16'h0, 2'b00, 1'b0, 1'b1);
    vecs[6] = mk(96'hA5_FF_FE_00_04_01_02_03_04_0A_00_00, 4'd10, 4'd15, 2'd2,
                 16'hFFFE, 16'h0201, 2'b11, 16'h0000, 16'h0403, 2'b11, 1'b1, 1'b0);

    // Reset state, sampled while rst is held
    repeat (3) @(negedge clk);
    chk("rst mem_valid", {31'd0, mem_valid}, 32'd0);
    chk("rst mem_addr",  {16'd0, mem_addr},  32'd0);
    chk("rst mem_wdata", {16'd0, mem_wdata}, 32'd0);
    chk("rst mem_wstrb", {30'd0, mem_wstrb}, 32'd0);
    chk("rst done",      {31'd0, done},      32'd0);
    chk("rst error",     {31'd0, error},     32'd0);
    chk("rst cpu_rst",   {31'd0, cpu_rst},   32'd1);

    for (int i = 0; i < NV; i++) begin
      apply_reset();
      base = wlog.size();
      for (int j = 0; j < int'(vecs[i].n); j++) begin
        fb = vecs[i].b[95-8*j -: 8];
        send_byte(fb, (j == int'(vecs[i].bad)) ? 1'b0 : 1'b1);
      end
      repeat (30) @(negedge clk);
      chk($sformatf("v%0d done", i),    {31'd0, done},    {31'd0, vecs[i].exp_done});
      chk($sformatf("v%0d error", i),   {31'd0, error},   {31'd0, vecs[i].exp_err});
      chk($sformatf("v%0d cpu_rst", i), {31'd0, cpu_rst}, {31'd0, ~vecs[i].exp_done});
      chk($sformatf("v%0d nwrites", i), wlog.size() - base, {30'd0, vecs[i].nwr});
      if (vecs[i].nwr >= 2'd1 && wlog.size() > base) begin
        e = wlog[base];
        chk($sformatf("v%0d w0 addr", i), {16'd0, e[31:16]}, {16'd0, vecs[i].a0});
        chk($sformatf("v%0d w0 data", i), {16'd0, e[15:0]},  {16'd0, vecs[i].d0});
        chk($sformatf("v%0d w0 strb", i), {30'd0, e[33:32]}, {30'd0, vecs[i].s0});
      end
      if (vecs[i].nwr >= 2'd2 && wlog.size() > base + 1) begin
        e = wlog[base+1];
        chk($sformatf("v%0d w1 addr", i), {16'd0, e[31:16]}, {16'd0, vecs[i].a1});
        chk($sformatf("v%0d w1 data", i), {16'd0, e[15:0]},  {16'd0, vecs[i].d1});
        chk($sformatf("v%0d w1 strb", i), {30'd0, e[33:32]}, {30'd0, vecs[i].s1});
      end
    end

    // rst pulsed while a write request is outstanding
    apply_reset();
    send_byte(8'hA5, 1'b1);
    send_byte(8'h00, 1'b1);
    send_byte(8'h10, 1'b1);
    send_byte(8'h00, 1'b1);
    send_byte(8'h04, 1'b1);
    send_byte(8'h11, 1'b1);
    rx = 1'b0;  // start bit of 0x22, then complete the byte by hand
    repeat (CPB) @(negedge clk);
    for (int k = 0; k < 8; k++) begin
      rx = (8'h22 >> k) & 8'h01 ? 1'b1 : 1'b0;
      repeat (CPB) @(negedge clk);
    end
    rx = 1'b1;
    seen = 1'b0;
    for (int t = 0; t < 20 && !seen; t++) begin
      @(negedge clk);
      if (mem_valid && !mem_ready) seen = 1'b1;
    end
    chk("rstseq valid seen", {31'd0, seen}, 32'd1);
    base = wlog.size();
    rst = 1'b1;
    @(negedge clk);
    chk("rstseq valid dropped", {31'd0, mem_valid}, 32'd0);
    chk("rstseq cpu_rst", {31'd0, cpu_rst}, 32'd1);
    rst = 1'b0;
    @(negedge clk);
    chk("rstseq no aborted write", wlog.size() - base, 32'd0);
    rbase = ready_cnt;
    repeat (4) @(negedge clk);
    for (int j = 0; j < 10; j++) begin
      fb = vecs[0].b[95-8*j -: 8];
      send_byte(fb, 1'b1);
    end
    repeat (30) @(negedge clk);
    chk("rstseq done", {31'd0, done}, 32'd1);
    chk("rstseq nwrites", wlog.size() - base, 32'd2);
    chk("rstseq ready pulses", ready_cnt - rbase, 32'd2);
    if (wlog.size() > base + 1) begin
      e = wlog[base+1];
      chk("rstseq w1", {14'd0, e[33:16], 16'd0} | {16'd0, e[15:0]},
          {14'd0, 2'b11, 16'h0012, 16'h4433});
    end

    // Bytes after DONE are ignored
    send_byte(8'h5A, 1'b1);
    send_byte(8'h00, 1'b0);
    repeat (10) @(negedge clk);
    chk("post-done done", {31'd0, done}, 32'd1);
    chk("post-done error", {31'd0, error}, 32'd0);
    chk("post-done no writes", wlog.size() - base, 32'd2);

    chk("bus stable while valid", stab_viol, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
